gpu_draw_line_stream: RTL and testbench
=======================================

Name: gpu_draw_line_stream

Overview:
- Parametrised next-generation Bresenham line rasteriser for the GPU draw pipeline.
- Accepts a line command (endpoints plus flat RGB colour) and emits one pixel per accepted handshake on a valid/ready stream toward the framebuffer writer.
- Adds over the previous generation: parametrised widths, output back-pressure, latched command inputs, optional endpoint suppression (polyline chaining), abort, and a single-cycle done pulse.

Parameters:
- WIDTH_BITS, 10, bits of X coordinate
- HEIGHT_BITS, 9, bits of Y coordinate
- CHANNEL_BITS, 8, bits per colour channel

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  synchronous active-low reset
- start  in  1  command request; sampled only in IDLE
- abort  in  1  cancel current line; sampled in LOAD/DRAW
- skip_last  in  1  1 = do not emit endpoint (x2,y2); latched at start
- x1  in  WIDTH_BITS  start X (unsigned)
- y1  in  HEIGHT_BITS  start Y
- x2  in  WIDTH_BITS  end X
- y2  in  HEIGHT_BITS  end Y
- r_i, g_i, b_i  in  CHANNEL_BITS each  line colour
- px_ready  in  1  downstream accepts pixel
- px_valid  out  1  X/Y/colour valid
- X  out  WIDTH_BITS  pixel X
- Y  out  HEIGHT_BITS  pixel Y
- r_o, g_o, b_o  out  CHANNEL_BITS each  pixel colour
- busy  out  1  high in LOAD and DRAW
- done  out  1  one-cycle pulse on normal completion

Behaviour:
- Clock and reset: one clock, clk; reset n_rst is synchronous, active-low, sampled on the rising edge of clk.
- Reset: state IDLE; px_valid=0, busy=0, done=0; X, Y, r_o, g_o, b_o = 0; internal err = 0.
- States: IDLE, LOAD, DRAW, FINISH.
- IDLE: when start=1, latch x1, y1, x2, y2, colour and skip_last, then go to LOAD. start is level-sampled; holding it high re-triggers only after FINISH returns to IDLE.
- LOAD (1 cycle): compute and register the following, then go to DRAW.
  - dx = |x2-x1|, dy = -|y2-y1|, err = dx+dy.
  - sx = +1 if x1<x2 else -1; sy = +1 if y1<y2 else -1.
  - X=x1, Y=y1.
  - Special case: if skip_last=1 and (x1,y1)==(x2,y2), go to FINISH with no pixel.
- Arithmetic: dx, dy, err and e2 are signed with max(WIDTH_BITS,HEIGHT_BITS)+2 bits. e2 = err<<1 is combinational. No overflow is possible for in-range coordinates.
- DRAW: px_valid=1 with the current X/Y/colour. A pixel transfers on the cycle where px_valid and px_ready are both 1.
  - While px_ready=0, X, Y, colour and err hold stable.
  - On a transfer, if (X,Y)==(x2,y2), go to FINISH.
  - Otherwise step, using e2 from the pre-update err, with both updates in the same cycle:
    - if e2>=dy: err+=dy, X+=sx;
    - if e2<=dx: err+=dx, Y+=sy.
  - skip_last=1: when the stepped position equals (x2,y2), go to FINISH instead of presenting it.
- Throughput: first pixel valid 2 cycles after start is sampled; then 1 pixel/cycle while px_ready=1.
- FINISH (1 cycle): done=1, busy=0, px_valid=0, then go to IDLE. done is never high for more than one cycle.
- abort=1 in LOAD or DRAW: go to IDLE next cycle; px_valid=0, busy=0, no done pulse. A pixel handshaking in that same cycle counts as transferred.
- Command inputs may change freely after start is sampled; the latched copies are used.
- Reset mid-line: immediate return to reset state; no done pulse.
- start in LOAD/DRAW/FINISH is ignored.

Test Plan:
- (0,0)->(4,0), px_ready=1 -> start at cycle 0; pixels x=0,1,2,3,4 (y=0) on cycles 2-6; done pulse at cycle 7 only; busy high cycles 1-6.
- Steep line (0,0)->(1,3) -> exactly (0,0),(0,1),(1,2),(1,3). Reverse horizontal (3,2)->(0,2) -> x=3,2,1,0 at y=2.
- Back-pressure on (0,0)->(3,3): px_ready=0 for 3 cycles while (1,1) is presented -> (1,1) held stable; final sequence (0,0),(1,1),(2,2),(3,3) with no loss or duplication.
- skip_last=1 on (0,0)->(2,0) -> (0,0),(1,0) only, then done. skip_last=1 on (5,5)->(5,5) -> zero pixels; done 2 cycles after start.
- abort asserted on the 3rd pixel of (0,0)->(9,0) -> 3 pixels transferred, IDLE next cycle, no done. A new start is then accepted normally.
- n_rst=0 mid-line -> next edge: px_valid=0, busy=0, X=Y=0; change x1 during DRAW -> output unaffected.

Source files
------------

// File: rtl/gpu_draw_line_stream_if.sv
// Command and pixel-stream bundle for the Bresenham line rasteriser.
// The master side issues line commands and consumes pixels; the slave side is the rasteriser.
interface gpu_draw_line_stream_if #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
);
  logic                    start;
  logic                    abort;
  logic                    skip_last;
  logic [WIDTH_BITS-1:0]   x1;
  logic [HEIGHT_BITS-1:0]  y1;
  logic [WIDTH_BITS-1:0]   x2;
  logic [HEIGHT_BITS-1:0]  y2;
  logic [CHANNEL_BITS-1:0] r_i;
  logic [CHANNEL_BITS-1:0] g_i;
  logic [CHANNEL_BITS-1:0] b_i;
  logic                    px_ready;
  logic                    px_valid;
  logic [WIDTH_BITS-1:0]   X;
  logic [HEIGHT_BITS-1:0]  Y;
  logic [CHANNEL_BITS-1:0] r_o;
  logic [CHANNEL_BITS-1:0] g_o;
  logic [CHANNEL_BITS-1:0] b_o;
  logic                    busy;
  logic                    done;

  modport master (
    output start, abort, skip_last, x1, y1, x2, y2, r_i, g_i, b_i, px_ready,
    input  px_valid, X, Y, r_o, g_o, b_o, busy, done
  );

  modport slave (
    input  start, abort, skip_last, x1, y1, x2, y2, r_i, g_i, b_i, px_ready,
    output px_valid, X, Y, r_o, g_o, b_o, busy, done
  );
endinterface

// File: rtl/gpu_draw_line_stream.sv
// Bresenham line rasteriser: latches a line command and streams one pixel per
// valid/ready handshake, with endpoint suppression, abort and a done pulse.
module gpu_draw_line_stream #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8
) (
  input logic                   clk,
  input logic                   n_rst,
  gpu_draw_line_stream_if.slave bus
);

  localparam int AW = ((WIDTH_BITS > HEIGHT_BITS) ? WIDTH_BITS : HEIGHT_BITS) + 2;
  localparam logic signed [AW-1:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, LOAD, DRAW, FINISH} state_t;

  state_t                  state;
  logic [WIDTH_BITS-1:0]   x1_l, x2_l, x_q, x_step;
  logic [HEIGHT_BITS-1:0]  y1_l, y2_l, y_q, y_step;
  logic [CHANNEL_BITS-1:0] r_q, g_q, b_q;
  logic                    skip_l, sx_neg, sy_neg;
  logic                    px_valid_q, busy_q, done_q;
  logic signed [AW-1:0]    dx, dy, err, e2, err_step;
  logic signed [AW-1:0]    x1_e, x2_e, y1_e, y2_e;
  logic                    step_x, step_y, at_end, step_at_end, xfer;

  function automatic logic signed [AW-1:0] abs_diff(input logic signed [AW-1:0] a,
                                                    input logic signed [AW-1:0] b);
    logic signed [AW-1:0] d;
    d = a - b;
    return (d < ZERO) ? -d : d;
  endfunction

  assign x1_e = $signed({{(AW-WIDTH_BITS){1'b0}}, x1_l});
  assign x2_e = $signed({{(AW-WIDTH_BITS){1'b0}}, x2_l});
  assign y1_e = $signed({{(AW-HEIGHT_BITS){1'b0}}, y1_l});
  assign y2_e = $signed({{(AW-HEIGHT_BITS){1'b0}}, y2_l});

  // Both axis decisions use e2 from the pre-update error term.
  always_comb begin
    e2          = err <<< 1;
    step_x      = (e2 >= dy);
    step_y      = (e2 <= dx);
    err_step    = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
    x_step      = x_q;
    y_step      = y_q;
    if (step_x) x_step = sx_neg ? (x_q - 1'b1) : (x_q + 1'b1);
    if (step_y) y_step = sy_neg ? (y_q - 1'b1) : (y_q + 1'b1);
    at_end      = (x_q == x2_l) && (y_q == y2_l);
    step_at_end = (x_step == x2_l) && (y_step == y2_l);
    xfer        = px_valid_q && bus.px_ready;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= IDLE;
      px_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      x1_l       <= '0;
      y1_l       <= '0;
      x2_l       <= '0;
      y2_l       <= '0;
      skip_l     <= 1'b0;
      sx_neg     <= 1'b0;
      sy_neg     <= 1'b0;
      dx         <= ZERO;
      dy         <= ZERO;
      err        <= ZERO;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x1_l   <= bus.x1;
            y1_l   <= bus.y1;
            x2_l   <= bus.x2;
            y2_l   <= bus.y2;
            r_q    <= bus.r_i;
            g_q    <= bus.g_i;
            b_q    <= bus.b_i;
            skip_l <= bus.skip_last;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            dx     <= abs_diff(x2_e, x1_e);
            dy     <= -abs_diff(y2_e, y1_e);
            err    <= abs_diff(x2_e, x1_e) - abs_diff(y2_e, y1_e);
            sx_neg <= !(x1_l < x2_l);
            sy_neg <= !(y1_l < y2_l);
            x_q    <= x1_l;
            y_q    <= y1_l;
            // A suppressed endpoint on a zero-length line leaves nothing to draw.
            if (skip_l && (x1_l == x2_l) && (y1_l == y2_l)) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= FINISH;
            end else begin
              px_valid_q <= 1'b1;
              state      <= DRAW;
            end
          end
        end
        DRAW: begin
          if (bus.abort) begin
            px_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state      <= IDLE;
          end else if (xfer) begin
            if (at_end) begin
              px_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= FINISH;
            end else begin
              err <= err_step;
              x_q <= x_step;
              y_q <= y_step;
              if (skip_l && step_at_end) begin
                px_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state      <= FINISH;
              end
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.px_valid = px_valid_q;
  assign bus.X        = x_q;
  assign bus.Y        = y_q;
  assign bus.r_o      = r_q;
  assign bus.g_o      = g_q;
  assign bus.b_o      = b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_gpu_draw_line_stream.sv
// Scoreboarded bench for gpu_draw_line_stream: expected pixels are queued as
// each command is issued and popped on every observed handshake.
module tb_gpu_draw_line_stream;

  localparam int WB = 10;
  localparam int HB = 9;
  localparam int CB = 8;

  typedef struct packed {
    logic [WB-1:0] x;
    logic [HB-1:0] y;
    logic [CB-1:0] r;
    logic [CB-1:0] g;
    logic [CB-1:0] b;
  } px_t;

  logic clk = 1'b0;
  logic n_rst;
  int   total = 0;
  int   bad = 0;
  int   cr, cg, cb;
  logic done_prev = 1'b0;
  px_t  exp_q[$];

  gpu_draw_line_stream_if #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) bus ();

  gpu_draw_line_stream #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB), .CHANNEL_BITS(CB)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every handshake must match the oldest expected pixel.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus.px_valid === 1'b1 && bus.px_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pixel: got (%0d,%0d) required no pixel", bus.X, bus.Y);
      end else begin
        px_t p;
        p = exp_q.pop_front();
        if (bus.X !== p.x || bus.Y !== p.y || bus.r_o !== p.r || bus.g_o !== p.g || bus.b_o !== p.b) begin
          bad++;
          $display("FAIL pixel: got (%0d,%0d rgb %0d/%0d/%0d) required (%0d,%0d rgb %0d/%0d/%0d)",
                   bus.X, bus.Y, bus.r_o, bus.g_o, bus.b_o, p.x, p.y, p.r, p.g, p.b);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      total++;
      if (done_prev) begin
        bad++;
        $display("FAIL done_width: got done high 2 cycles required 1");
      end
    end
    done_prev = (bus.done === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int ax1, input int ay1, input int ax2, input int ay2,
                       input logic sk, input int r, input int g, input int b);
    bus.x1 = WB'(ax1);
    bus.y1 = HB'(ay1);
    bus.x2 = WB'(ax2);
    bus.y2 = HB'(ay2);
    bus.skip_last = sk;
    bus.r_i = CB'(r);
    bus.g_i = CB'(g);
    bus.b_i = CB'(b);
    cr = r; cg = g; cb = b;
    bus.start = 1'b1;
  endtask

  task automatic push(input int px, input int py);
    px_t p;
    p.x = WB'(px);
    p.y = HB'(py);
    p.r = CB'(cr);
    p.g = CB'(cg);
    p.b = CB'(cb);
    exp_q.push_back(p);
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1;
      step();
      if (seen) break;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done: got no done within 40 cycles required done pulse", name);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing: got %0d pixels outstanding required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.start = 0; bus.abort = 0; bus.skip_last = 0; bus.px_ready = 0;
    bus.x1 = 0; bus.y1 = 0; bus.x2 = 0; bus.y2 = 0;
    bus.r_i = 0; bus.g_i = 0; bus.b_i = 0;
    step(); step();
    @(negedge clk);
    total++;
    if (bus.px_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got valid=%b busy=%b done=%b required 0 0 0", bus.px_valid, bus.busy, bus.done);
    end
    total++;
    if (bus.X !== '0 || bus.Y !== '0 || bus.r_o !== '0 || bus.g_o !== '0 || bus.b_o !== '0) begin
      bad++;
      $display("FAIL reset_data: got X=%0d Y=%0d rgb %0d/%0d/%0d required all 0", bus.X, bus.Y, bus.r_o, bus.g_o, bus.b_o);
    end
    step();
    n_rst = 1'b1;
    bus.px_ready = 1'b1;
    step();
  endtask

  task automatic test_timing();
    logic ev, eb, ed;
    issue(0, 0, 4, 0, 1'b0, 10, 20, 30);
    for (int i = 0; i <= 4; i++) push(i, 0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      eb = (c >= 1 && c <= 6);
      ed = (c == 7);
      ev = (c >= 2 && c <= 6);
      total++;
      if (bus.busy !== eb) begin
        bad++; $display("FAIL timing_busy c%0d: got %b required %b", c, bus.busy, eb);
      end
      total++;
      if (bus.done !== ed) begin
        bad++; $display("FAIL timing_done c%0d: got %b required %b", c, bus.done, ed);
      end
      total++;
      if (bus.px_valid !== ev) begin
        bad++; $display("FAIL timing_valid c%0d: got %b required %b", c, bus.px_valid, ev);
      end
      if (ev) begin
        total++;
        if (bus.X !== WB'(c - 2) || bus.Y !== '0) begin
          bad++; $display("FAIL timing_xy c%0d: got (%0d,%0d) required (%0d,0)", c, bus.X, bus.Y, c - 2);
        end
      end
      step();
      bus.start = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL timing_missing: got %0d outstanding required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_steep_reverse();
    issue(0, 0, 1, 3, 1'b0, 1, 2, 3);
    push(0, 0); push(0, 1); push(1, 2); push(1, 3);
    step(); bus.start = 1'b0;
    wait_done("steep");
    issue(3, 2, 0, 2, 1'b0, 200, 100, 50);
    push(3, 2); push(2, 2); push(1, 2); push(0, 2);
    step(); bus.start = 1'b0;
    wait_done("reverse");
  endtask

  task automatic test_backpressure();
    bit found = 0;
    issue(0, 0, 3, 3, 1'b0, 7, 8, 9);
    push(0, 0); push(1, 1); push(2, 2); push(3, 3);
    step(); bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.px_valid === 1'b1 && bus.X === '0 && bus.Y === '0) found = 1;
      step();
      if (found) break;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL bp_first: got no (0,0) within 10 cycles required (0,0)");
    end
    bus.px_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.px_valid !== 1'b1 || bus.X !== WB'(1) || bus.Y !== HB'(1)) begin
        bad++; $display("FAIL bp_hold k%0d: got valid=%b (%0d,%0d) required 1 (1,1)", k, bus.px_valid, bus.X, bus.Y);
      end
      step();
    end
    bus.px_ready = 1'b1;
    wait_done("bp");
  endtask

  task automatic test_skip_last();
    issue(0, 0, 2, 0, 1'b1, 4, 5, 6);
    push(0, 0); push(1, 0);
    step(); bus.start = 1'b0;
    wait_done("skip");
    issue(5, 5, 5, 5, 1'b1, 4, 5, 6);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (bus.done !== (c == 2)) begin
        bad++; $display("FAIL skip_point_done c%0d: got %b required %b", c, bus.done, (c == 2));
      end
      total++;
      if (bus.px_valid !== 1'b0) begin
        bad++; $display("FAIL skip_point_valid c%0d: got %b required 0", c, bus.px_valid);
      end
      step();
      bus.start = 1'b0;
    end
    bus.skip_last = 1'b0;
  endtask

  task automatic test_abort();
    issue(0, 0, 9, 0, 1'b0, 11, 12, 13);
    push(0, 0); push(1, 0); push(2, 0);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (bus.px_valid !== 1'b1 || bus.X !== WB'(2)) begin
          bad++; $display("FAIL abort_third: got valid=%b X=%0d required 1 X=2", bus.px_valid, bus.X);
        end
      end
      if (c >= 5) begin
        total++;
        if (bus.px_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
          bad++; $display("FAIL abort_idle c%0d: got valid=%b busy=%b done=%b required 0 0 0", c, bus.px_valid, bus.busy, bus.done);
        end
      end
      step();
      bus.start = 1'b0;
      if (c == 3) bus.abort = 1'b1;
      if (c == 4) bus.abort = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL abort_count: got %0d outstanding required 0", exp_q.size());
    end
    exp_q.delete();
    issue(1, 1, 2, 1, 1'b0, 3, 3, 3);
    push(1, 1); push(2, 1);
    step(); bus.start = 1'b0;
    wait_done("after_abort");
  endtask

  task automatic test_reset_midline();
    issue(0, 0, 9, 0, 1'b0, 21, 22, 23);
    push(0, 0); push(1, 0); push(2, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 6) begin
        total++;
        if (bus.px_valid !== 1'b0 || bus.busy !== 1'b0 || bus.X !== '0 || bus.Y !== '0) begin
          bad++; $display("FAIL rst_mid: got valid=%b busy=%b (%0d,%0d) required 0 0 (0,0)", bus.px_valid, bus.busy, bus.X, bus.Y);
        end
      end
      if (c == 7) begin
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
          bad++; $display("FAIL rst_mid_done: got done=%b busy=%b required 0 0", bus.done, bus.busy);
        end
      end
      step();
      bus.start = 1'b0;
      if (c == 4) begin bus.px_ready = 1'b0; n_rst = 1'b0; end
      if (c == 5) n_rst = 1'b1;
    end
    bus.px_ready = 1'b1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL rst_mid_count: got %0d outstanding required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_input_change();
    issue(0, 0, 3, 0, 1'b0, 90, 91, 92);
    push(0, 0); push(1, 0); push(2, 0); push(3, 0);
    step();
    bus.start = 1'b0;
    step();
    bus.x1 = 10'd77; bus.x2 = 10'd5; bus.y1 = 9'd3; bus.y2 = 9'd8;
    bus.r_i = 8'd1; bus.g_i = 8'd2; bus.b_i = 8'd3; bus.skip_last = 1'b1;
    wait_done("latched");
    bus.skip_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    issue(0, 0, 1, 0, 1'b0, 55, 66, 77);
    push(0, 0); push(1, 0); push(0, 0); push(1, 0);
    for (int i = 0; i < 30 && dones < 2; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      step();
    end
    bus.start = 1'b0;
    total++;
    if (dones != 2) begin
      bad++; $display("FAIL b2b_dones: got %0d required 2", dones);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (bus.busy !== 1'b0) begin
        bad++; $display("FAIL b2b_idle k%0d: got busy=%b required 0", k, bus.busy);
      end
      step();
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL b2b_missing: got %0d outstanding required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_timing();
    test_steep_reverse();
    test_backpressure();
    test_skip_last();
    test_abort();
    test_reset_midline();
    test_input_change();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
